// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads four bytes from a byte-wide, 1-cycle-latency
// instruction memory, assembles a big-endian 32-bit word and presents it with
// its PC over a valid/ready handshake. Redirects restart fetch at a new PC.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_data,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  fetch_pc, fetch_pc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        pend, pend_nxt;
  logic [1:0]  pend_idx, pend_idx_nxt;
  logic [31:0] instr_nxt;
  logic [7:0]  instr_pc_nxt;
  logic        instr_valid_nxt;

  // Read strobe is gated by rst_n so no read is issued while reset is held.
  assign mem_rd   = rst_n && (state == FETCH);
  assign mem_addr = fetch_pc + {6'd0, cnt};

  // Next-state and datapath update; redirect overrides everything last.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    cnt_nxt         = cnt;
    pend_nxt        = 1'b0;
    pend_idx_nxt    = pend_idx;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;

    if (pend) begin
      case (pend_idx)
        2'd0:    instr_nxt[31:24] = mem_data;
        2'd1:    instr_nxt[23:16] = mem_data;
        2'd2:    instr_nxt[15:8]  = mem_data;
        default: instr_nxt[7:0]   = mem_data;
      endcase
    end

    case (state)
      FETCH: begin
        pend_nxt     = 1'b1;
        pend_idx_nxt = cnt;
        cnt_nxt      = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        instr_valid_nxt = 1'b1;
        instr_pc_nxt    = fetch_pc;
        fetch_pc_nxt    = fetch_pc + 8'd4;
        cnt_nxt         = 2'd0;
        state_nxt       = HOLD;
      end
      HOLD: begin
        if (instr_valid && instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    // In-flight return data is dropped by restoring instr and clearing pend.
    if (redirect) begin
      state_nxt       = FETCH;
      fetch_pc_nxt    = redirect_pc;
      cnt_nxt         = 2'd0;
      pend_nxt        = 1'b0;
      instr_valid_nxt = 1'b0;
      instr_nxt       = instr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Fetch address, byte tracking and output word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      cnt         <= '0;
      pend        <= 1'b0;
      pend_idx    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      pend_idx    <= pend_idx_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a cycle-level reference model queues
// expected words (with arrival cycle) and expected memory bus activity; a
// negedge monitor pops and compares.
module tb_instr_fetch_unit;

  localparam logic [7:0] RPC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned due; logic [7:0] pc; logic [31:0] word; } item_t;
  typedef struct { int unsigned c; logic rd; logic [7:0] addr; } bus_t;
  item_t sq[$];
  bus_t  bq[$];

  int unsigned n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] pc);
    logic [7:0] a1, a2, a3;
    a1 = pc + 8'd1; a2 = pc + 8'd2; a3 = pc + 8'd3;
    return {mem[pc], mem[a1], mem[a2], mem[a3]};
  endfunction

  // Reference model: fetch of m_pc starts in cycle m_start, word due 5 later.
  bit          m_known = 0, prev_rst_low = 0;
  int unsigned m_start = 0;
  logic [7:0]  m_pc = RPC;

  task automatic flush_future();
    while (sq.size() > 0 && sq[sq.size()-1].due > cyc) void'(sq.pop_back());
  endtask

  task automatic push_word();
    item_t it;
    it.due = m_start + 5; it.pc = m_pc; it.word = word_at(m_pc);
    sq.push_back(it);
  endtask

  task automatic step(input bit r, input bit rd, input logic [7:0] rpc, input bit rdy);
    bus_t b;
    bit   mvalid;
    @(posedge clk); #1;
    rst_n = r; redirect = rd && r; redirect_pc = rpc; instr_ready = rdy;
    if (!r) begin
      flush_future();
      prev_rst_low = 1;
      b.c = cyc; b.rd = 1'b0; b.addr = 8'h00;
      bq.push_back(b);
    end else begin
      if (prev_rst_low) begin
        prev_rst_low = 0; m_known = 1; m_start = cyc; m_pc = RPC; push_word();
      end
      if (m_known) begin
        b.c = cyc;
        b.rd = (cyc >= m_start) && (cyc <= m_start + 3);
        b.addr = m_pc + 8'(cyc - m_start);
        bq.push_back(b);
        mvalid = (cyc >= m_start + 5);
        if (rd) begin
          flush_future(); m_start = cyc + 1; m_pc = rpc; push_word();
        end else if (mvalid && rdy) begin
          m_pc = m_pc + 8'd4; m_start = cyc + 1; push_word();
        end
      end
    end
  endtask

  task automatic run_until(input int unsigned target, input bit rdy);
    while (cyc + 1 < target) step(1, 0, 8'h00, rdy);
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) step(1, 0, 8'h00, rdy);
  endtask

  // Monitor: reset values, memory bus, word arrival/content and hold stability.
  bit          rst_q = 1'b1;
  bit          open = 0, close_pend = 0;
  logic [31:0] held_i;
  logic [7:0]  held_pc;
  always @(posedge clk) rst_q <= rst_n;

  always @(negedge clk) begin
    bit    closed;
    item_t it;
    bus_t  b;
    closed = close_pend;
    if (!rst_q) begin
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'(RPC));
    end
    while (bq.size() > 0 && bq[0].c < cyc) void'(bq.pop_front());
    if (bq.size() > 0 && bq[0].c == cyc) begin
      b = bq.pop_front();
      check("mem_rd", 32'(mem_rd), 32'(b.rd));
      if (b.rd) check("mem_addr", 32'(mem_addr), 32'(b.addr));
    end
    if (instr_valid) begin
      if (closed) open = 0;
      if (!open) begin
        if (sq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got pc %h instr %h expected no word (cycle %0d)", instr_pc, instr, cyc);
        end else begin
          it = sq.pop_front();
          check("valid_cycle", cyc, it.due);
          check("instr_pc", 32'(instr_pc), 32'(it.pc));
          check("instr", instr, it.word);
        end
        open = 1; held_i = instr; held_pc = instr_pc;
      end else begin
        check("instr_hold", instr, held_i);
        check("instr_pc_hold", 32'(instr_pc), 32'(held_pc));
      end
    end else begin
      if (open && !closed) begin
        n_cmp++; n_err++;
        $display("FAIL valid_dropped: got instr_valid 0 expected 1 (cycle %0d)", cyc);
      end
      open = 0;
      if (sq.size() > 0 && cyc > sq[0].due) begin
        it = sq.pop_front();
        n_cmp++; n_err++;
        $display("FAIL late_word: got no word expected pc %h by cycle %0d (cycle %0d)", it.pc, it.due, cyc);
      end
    end
    close_pend = (instr_valid && instr_ready) || redirect || !rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB; mem[8'h22] = 8'hCC; mem[8'h23] = 8'hDD;

    // Reset, then basic fetch from RESET_PC with ready high.
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    idle(6, 1);

    // Backpressure on the word at pc 0x04, then a single-cycle accept.
    run_until(m_start + 5 + 20, 0);
    step(1, 0, 8'h00, 1);
    idle(3, 0);

    // Redirect after two bytes issued.
    run_until(m_start + 2, 0);
    step(1, 1, 8'h20, 0);
    run_until(m_start + 5, 0);
    step(1, 0, 8'h00, 1);

    // Redirect in DRAIN, then redirect coincident with a handshake in HOLD.
    run_until(m_start + 4, 0);
    step(1, 1, 8'h40, 0);
    run_until(m_start + 5, 0);
    step(1, 1, 8'h80, 1);
    idle(8, 1);

    // One-cycle reset mid-fetch (cnt=2).
    run_until(m_start + 2, 1);
    step(0, 0, 8'h00, 1);
    idle(8, 1);

    // Randomized traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      step(($urandom_range(199) != 0), ($urandom_range(31) == 0),
           8'($urandom), 1'($urandom));
    end

    // Address wrap across 0xFF -> 0x00.
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
    step(1, 1, 8'hFE, 0);
    run_until(m_start + 5, 0);
    step(1, 0, 8'h00, 1);
    idle(12, 0);

    @(negedge clk); #1;
    check("queue_empty", 32'(sq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
